// File: rtl/rescue_pkg.sv
// Shared definitions for the Rescue-Prime sponge front-end.
// Holds field/sponge geometry, the BN254 scalar modulus, the field element
// and sponge state types, the absorber FSM encoding and the input reduction.
package rescue_pkg;

   localparam int unsigned N_BITS      = 254;
   localparam int unsigned STATE_SIZE  = 3;
   localparam int unsigned RATE        = 2;
   localparam int unsigned LANES       = 13;
   localparam int unsigned CAPACITY    = STATE_SIZE - RATE;
   localparam int unsigned BLOCK_ELEMS = RATE * LANES;
   localparam int unsigned ELEM_W      = $clog2(BLOCK_ELEMS);
   localparam int unsigned LANE_W      = $clog2(LANES);
   localparam int unsigned SLOT_W      = $clog2(STATE_SIZE);

   typedef logic [N_BITS-1:0] felt_t;

   // BN254 scalar field prime
   localparam felt_t PRIME_MODULUS =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   // One state element per lane, then one row per state slot: st[slot][lane]
   typedef felt_t    [LANES-1:0]      laneRow_t;
   typedef laneRow_t [STATE_SIZE-1:0] spongeState_t;

   typedef enum logic [2:0] {
      ABSORB,
      LAUNCH,
      WAIT,
      CAPTURE,
      SQUEEZE
   } spongeFsm_t;

   // Canonical form of a raw 254-bit word; one subtraction is enough as 2^254 < 2p
   function automatic felt_t reduceOnce(input felt_t x);
      return (x >= PRIME_MODULUS) ? felt_t'(x - PRIME_MODULUS) : x;
   endfunction

endpackage

// File: rtl/mod_add_p.sv
// Combinational modular adder: (a + b) mod p for canonical operands a, b < p.
// Ports:
//   a, b      in   canonical field elements
//   modSum_c  out  (a + b) mod p, combinational
module mod_add_p
   import rescue_pkg::*;
(
   input  felt_t a,
   input  felt_t b,
   output felt_t modSum_c
);

   logic [N_BITS:0] rawSum;
   felt_t           wrapped;

   // Sum needs one extra bit; a single conditional subtract brings it back below p
   assign rawSum   = {1'b0, a} + {1'b0, b};
   assign wrapped  = N_BITS'(rawSum - {1'b0, PRIME_MODULUS});
   assign modSum_c = (rawSum >= {1'b0, PRIME_MODULUS}) ? wrapped : rawSum[N_BITS-1:0];

endmodule

// File: rtl/rescue_sponge_absorber.sv
// Sponge front-end for the 13-lane Rescue-Prime permutation.
// Reduces incoming field elements mod p, absorbs them into the rate part of a
// 13-lane x 3-element state, launches one permutation per block and, after
// the final block, streams out state element 0 of every lane.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   in_data/in_valid/in_last    element stream; in_ready accepts
//   perm_state, perm_enable     permutation input state and launch pulse
//   perm_out, perm_done         permutation result and completion
//   digest_data/lane/valid      lane digest stream; digest_ready accepts
//   busy                        low only when idle between messages
module rescue_sponge_absorber
   import rescue_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  felt_t              in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output spongeState_t       perm_state,
   output logic               perm_enable,
   input  spongeState_t       perm_out,
   input  logic               perm_done,
   output felt_t              digest_data,
   output logic [LANE_W-1:0]  digest_lane,
   output logic               digest_valid,
   input  logic               digest_ready,
   output logic               busy
);

   localparam logic [ELEM_W-1:0] LAST_ELEM   = ELEM_W'(BLOCK_ELEMS - 1);
   localparam logic [ELEM_W-1:0] SLOT1_FIRST = ELEM_W'(LANES);
   localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);
   localparam logic [SLOT_W-1:0] DIGEST_SLOT = SLOT_W'(0);

   spongeFsm_t         state, stateNext;
   logic [ELEM_W-1:0]  elemCnt, elemCntNext;
   logic [LANE_W-1:0]  laneIdxNext;
   logic               lastSeen, lastSeenNext;
   logic               inMsg, inMsgNext;
   spongeState_t       st, stNext;
   felt_t              digestDataNext;
   logic               inReadyNext, permEnableNext, digestValidNext, busyNext;

   logic               accept, digestTake, slotSel;
   logic [SLOT_W-1:0]  absorbSlot;
   logic [LANE_W-1:0]  absorbLane;
   felt_t              reducedIn, absorbOld, absorbNew;

   // Handshakes qualified by the registered ready/valid the outside world sees
   assign accept     = (state == ABSORB) && in_ready && in_valid;
   assign digestTake = (state == SQUEEZE) && digest_valid && digest_ready;

   // Element e lands in lane e % LANES, slot e / LANES
   assign slotSel    = (elemCnt >= SLOT1_FIRST);
   assign absorbSlot = slotSel ? SLOT_W'(1) : SLOT_W'(0);
   assign absorbLane = slotSel ? LANE_W'(elemCnt - SLOT1_FIRST) : LANE_W'(elemCnt);

   assign reducedIn  = reduceOnce(in_data);
   assign absorbOld  = st[absorbSlot][absorbLane];

   // Single shared adder on the absorb path
   mod_add_p u_absorbAdd (
      .a        (absorbOld),
      .b        (reducedIn),
      .modSum_c (absorbNew)
   );

   assign perm_state = st;

   // Next-state, datapath updates and next values of the registered outputs
   always_comb begin
      stateNext       = state;
      elemCntNext     = elemCnt;
      laneIdxNext     = digest_lane;
      lastSeenNext    = lastSeen;
      inMsgNext       = inMsg;
      stNext          = st;
      inReadyNext     = 1'b0;
      permEnableNext  = 1'b0;
      digestValidNext = 1'b0;
      busyNext        = 1'b1;
      digestDataNext  = '0;

      unique case (state)
         ABSORB: begin
            if (accept) begin
               stNext[absorbSlot][absorbLane] = absorbNew;
               inMsgNext = 1'b1;
               if (in_last) lastSeenNext = 1'b1;
               // Early in_last leaves the untouched slots as-is (zero padding)
               if (in_last || (elemCnt == LAST_ELEM)) begin
                  elemCntNext = '0;
                  stateNext   = LAUNCH;
               end else begin
                  elemCntNext = elemCnt + ELEM_W'(1);
               end
            end
         end
         // perm_done deliberately not looked at here: a stale level is not completion
         LAUNCH: stateNext = WAIT;
         WAIT: begin
            if (perm_done) begin
               stNext    = perm_out;
               stateNext = CAPTURE;
            end
         end
         CAPTURE: begin
            laneIdxNext = '0;
            stateNext   = lastSeen ? SQUEEZE : ABSORB;
         end
         SQUEEZE: begin
            if (digestTake) begin
               if (digest_lane == LAST_LANE) begin
                  stNext       = '0;
                  laneIdxNext  = '0;
                  lastSeenNext = 1'b0;
                  inMsgNext    = 1'b0;
                  stateNext    = ABSORB;
               end else begin
                  laneIdxNext = digest_lane + LANE_W'(1);
               end
            end
         end
         default: stateNext = ABSORB;
      endcase

      inReadyNext     = (stateNext == ABSORB);
      permEnableNext  = (stateNext == LAUNCH);
      digestValidNext = (stateNext == SQUEEZE);
      busyNext        = !((stateNext == ABSORB) && (elemCntNext == '0) && !inMsgNext);
      // st only changes in SQUEEZE on exit, so the current st is the right source
      digestDataNext  = digestValidNext ? st[DIGEST_SLOT][laneIdxNext] : '0;
   end

   // FSM and control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ABSORB;
         elemCnt      <= '0;
         digest_lane  <= '0;
         lastSeen     <= 1'b0;
         inMsg        <= 1'b0;
         in_ready     <= 1'b0;
         perm_enable  <= 1'b0;
         digest_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= stateNext;
         elemCnt      <= elemCntNext;
         digest_lane  <= laneIdxNext;
         lastSeen     <= lastSeenNext;
         inMsg        <= inMsgNext;
         in_ready     <= inReadyNext;
         perm_enable  <= permEnableNext;
         digest_valid <= digestValidNext;
         busy         <= busyNext;
      end
   end

   // Sponge state and digest word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st          <= '0;
         digest_data <= '0;
      end else begin
         st          <= stNext;
         digest_data <= digestDataNext;
      end
   end

endmodule

// File: tb/tb_rescue_sponge_absorber.sv
// Self-checking bench for rescue_sponge_absorber with an identity permutation
// stub whose done pulse follows perm_enable by three cycles.
module tb_rescue_sponge_absorber;
   import rescue_pkg::*;

   typedef struct packed {
      logic [LANE_W-1:0] lane;
      felt_t             data;
   } expT;

   logic               clk = 1'b0;
   logic               reset;
   felt_t              in_data;
   logic               in_valid, in_last, in_ready;
   spongeState_t       perm_state, perm_out;
   logic               perm_enable, perm_done;
   felt_t              digest_data;
   logic [LANE_W-1:0]  digest_lane;
   logic               digest_valid, digest_ready, busy;

   int                 total = 0;
   int                 bad = 0;
   int                 enCnt = 0;
   logic [2:0]         doneSr;
   expT                sb[$];
   logic [255:0]       mdl [LANES];
   logic [255:0]       p256;
   int                 tbE = 0;

   always #5 clk = ~clk;

   rescue_sponge_absorber dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .perm_state   (perm_state),
      .perm_enable  (perm_enable),
      .perm_out     (perm_out),
      .perm_done    (perm_done),
      .digest_data  (digest_data),
      .digest_lane  (digest_lane),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready),
      .busy         (busy)
   );

   // Identity permutation stub
   assign perm_out  = perm_state;
   assign perm_done = doneSr[2];

   always @(posedge clk or negedge reset) begin
      if (!reset) doneSr <= '0;
      else        doneSr <= {doneSr[1:0], perm_enable};
   end

   always @(posedge clk) begin
      if (perm_enable) enCnt <= enCnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sendElem(input felt_t d, input logic last);
      int guard = 0;
      @(negedge clk);
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Drives a sequence, updates the reference model, checks each launch pulse
   task automatic runMsg(input felt_t vals[$], input bit lastAtEnd, input bit doPush);
      logic last;
      expT  ex;
      for (int i = 0; i < vals.size(); i++) begin
         last = lastAtEnd && (i == vals.size() - 1);
         sendElem(vals[i], last);
         if (tbE < int'(LANES)) mdl[tbE] = (mdl[tbE] + 256'(vals[i])) % p256;
         if (last || tbE == int'(BLOCK_ELEMS) - 1) begin
            tbE = 0;
            @(negedge clk);
            chk("launch_pulse", perm_enable, 1);
            chk("launch_in_ready_low", in_ready, 0);
         end else begin
            tbE++;
         end
      end
      if (doPush) begin
         for (int l = 0; l < int'(LANES); l++) begin
            ex.lane = LANE_W'(l);
            ex.data = N_BITS'(mdl[l]);
            sb.push_back(ex);
            mdl[l] = '0;
         end
      end
   endtask

   // Drains 13 digests against the scoreboard, optionally stalling every other cycle
   task automatic collect(input bit toggle);
      int    got = 0;
      int    guard = 0;
      logic  r = 1'b0;
      bit    held = 0;
      felt_t hd;
      logic [LANE_W-1:0] hl;
      expT   ex;
      while (got < int'(LANES) && guard < 300) begin
         @(negedge clk);
         guard++;
         if (held) begin
            chk("hold_data", digest_data, hd);
            chk("hold_lane", 256'(digest_lane), 256'(hl));
            held = 0;
         end
         r = toggle ? ~r : 1'b1;
         digest_ready = r;
         if (digest_valid) begin
            if (r) begin
               if (sb.size() == 0) begin
                  chk("unexpected_digest", digest_valid, 0);
               end else begin
                  ex = sb.pop_front();
                  chk("digest_lane", 256'(digest_lane), 256'(ex.lane));
                  chk("digest_data", digest_data, ex.data);
               end
               got++;
            end else begin
               hd   = digest_data;
               hl   = digest_lane;
               held = 1;
            end
         end
      end
      if (got < int'(LANES)) chk("digest_count", 256'(got), 256'(LANES));
      @(negedge clk);
      digest_ready = 1'b0;
      chk("after_squeeze_valid", digest_valid, 0);
      chk("after_squeeze_busy", busy, 0);
      chk("after_squeeze_ready", in_ready, 1);
      chk("after_squeeze_lane", 256'(digest_lane), 0);
   endtask

   initial begin
      felt_t msg[$];
      int    enBase;
      int    guard;

      p256 = 256'(PRIME_MODULUS);
      for (int l = 0; l < int'(LANES); l++) mdl[l] = '0;
      reset        = 1'b0;
      in_data      = '0;
      in_valid     = 1'b0;
      in_last      = 1'b0;
      digest_ready = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_perm_enable", perm_enable, 0);
      chk("rst_digest_valid", digest_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_perm_state_zero", 256'(perm_state == '0), 1);
      chk("rst_digest_lane", 256'(digest_lane), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_busy", busy, 0);

      // Single block 1..26, then latency of the first digest
      msg = {};
      for (int i = 0; i < 26; i++) msg.push_back(N_BITS'(i + 1));
      enBase = enCnt;
      runMsg(msg, 1, 1);
      chk("wait_busy", busy, 1);
      guard = 0;
      while (!perm_done && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("perm_done_seen", perm_done, 1);
      @(negedge clk);
      chk("capture_no_valid", digest_valid, 0);
      chk("capture_no_ready", in_ready, 0);
      @(negedge clk);
      chk("first_digest_valid", digest_valid, 1);
      chk("first_digest_lane", 256'(digest_lane), 0);
      collect(0);
      chk("single_block_enables", 256'(enCnt - enBase), 1);

      // Non-canonical input p+5 reduces to 5
      msg = {};
      msg.push_back(PRIME_MODULUS + N_BITS'(5));
      for (int i = 1; i < 26; i++) msg.push_back('0);
      runMsg(msg, 1, 1);
      collect(0);

      // Two blocks: (p-1) + 2 wraps to 1 in lane 0
      msg = {};
      msg.push_back(PRIME_MODULUS - N_BITS'(1));
      for (int i = 1; i < 26; i++) msg.push_back('0);
      enBase = enCnt;
      runMsg(msg, 0, 0);
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("between_blocks_ready", in_ready, 1);
      chk("between_blocks_busy", busy, 1);
      chk("between_blocks_no_digest", digest_valid, 0);
      msg = {};
      msg.push_back(N_BITS'(2));
      for (int i = 1; i < 26; i++) msg.push_back('0);
      runMsg(msg, 1, 1);
      collect(0);
      chk("two_block_enables", 256'(enCnt - enBase), 2);

      // Early last at e=3: lanes 4..12 stay zero
      msg = {N_BITS'(7), N_BITS'(8), N_BITS'(9), N_BITS'(10)};
      enBase = enCnt;
      runMsg(msg, 1, 1);
      collect(0);
      chk("short_msg_enables", 256'(enCnt - enBase), 1);

      // Back-pressure on the digest stream
      msg = {};
      for (int i = 0; i < 26; i++) msg.push_back(N_BITS'(100 + i));
      runMsg(msg, 1, 1);
      collect(1);

      // Reset while waiting on the permutation
      msg = {};
      for (int i = 0; i < 26; i++) msg.push_back(N_BITS'(5));
      runMsg(msg, 1, 0);
      @(negedge clk);
      chk("pre_reset_in_ready", in_ready, 0);
      reset = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_perm_enable", perm_enable, 0);
      chk("midrst_digest_valid", digest_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_perm_state_zero", 256'(perm_state == '0), 1);
      chk("midrst_digest_lane", 256'(digest_lane), 0);
      @(negedge clk);
      reset = 1'b1;
      tbE = 0;
      for (int l = 0; l < int'(LANES); l++) mdl[l] = '0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);
      msg = {};
      for (int i = 0; i < 26; i++) msg.push_back(N_BITS'(1));
      runMsg(msg, 1, 1);
      collect(0);
      chk("scoreboard_empty", 256'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rescue_sponge_absorber.md
# rescue_sponge_absorber

Sponge front-end directly upstream of the 13-lane `rescuePrime` permutation. Accepts a stream of 254-bit field elements and reduces each mod p. Absorbs them into a 13-lane × 3-element sponge state (rate 2, capacity 1) and launches the permutation once per block. After the last block it streams out the 13 lane digests (state element 0 of each lane).

## Interface
- `N_BITS`, 254, field element width
- `PRIME_MODULUS`, BN254 scalar prime (0x30644e72…f0000001), modulus p
- `STATE_SIZE`, 3, elements per lane state
- `RATE`, 2, rate elements per lane per block; capacity = STATE_SIZE−RATE
- `LANES`, 13, parallel permutation lanes
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `in_data`  in  N_BITS  input element
- `in_valid`  in  1  element present
- `in_last`  in  1  final element of message
- `in_ready`  out  1  element accepted when `in_valid && in_ready`
- `perm_state`  out  N_BITS×[STATE_SIZE][LANES]  drives permutation `inState`
- `perm_enable`  out  1  one-cycle launch pulse
- `perm_out`  in  N_BITS×[STATE_SIZE][LANES]  permutation `outState`
- `perm_done`  in  1  permutation finished
- `digest_data`  out  N_BITS  state[0] of lane `digest_lane`
- `digest_lane`  out  4  lane index 0..12
- `digest_valid`  out  1  digest word present
- `digest_ready`  in  1  consumer accepts
- `busy`  out  1  high in every state except ABSORB with element counter 0 and no message in progress

## Operation
- State regs `st[s][l]` reset to 0. Element counter `e` in 0..RATE·LANES−1 (0..25). Element e maps to lane `e % LANES`, slot `e / LANES` (elements 0–12 fill slot 0, 13–25 fill slot 1).
- Input reduction: `x = in_data ≥ p ? in_data − p : in_data`. A single subtraction suffices since 2^254 < 2p.
- Absorb: `st[slot][lane] <= (st[slot][lane] + x) mod p` on handshake. The sum is computed at N_BITS+1 width with one conditional subtraction.
- FSM:
  - ABSORB: `in_ready`=1. On handshake, absorb and increment e. When e=25 or `in_last` is accepted, go to LAUNCH and clear e.
  - LAUNCH: `perm_enable`=1 for exactly this cycle, then go to WAIT.
  - WAIT: on `perm_done`=1, latch `st <= perm_out` and go to CAPTURE.
  - CAPTURE: if the message's last element has been seen, go to SQUEEZE with lane index 0; else go to ABSORB.
  - SQUEEZE: `digest_valid`=1, `digest_data`=`st[0][idx]`. On handshake, increment idx. After lane 12 is accepted, clear all `st` to 0 and return to ABSORB.
- `in_last` on element e<25: the remaining slots of that block are zero-padded (no add) and the block launches immediately.
- A message is one or more blocks. Each block is exactly one permutation call.
- `perm_state` is driven continuously from `st`; it is stable from LAUNCH through WAIT.

## Timing
- Reset values: `in_ready`=1 after reset release (ABSORB), 0 while reset asserted. `perm_enable`=0, `digest_valid`=0, `busy`=0, `perm_state`=0, `digest_lane`=0.
- The last element of a block is accepted in cycle t. `perm_enable` is high in t+1.
- `perm_done` is ignored in the LAUNCH cycle, so a stale done level cannot be mistaken for completion.
- `perm_done` is first seen high in WAIT at cycle d. State is latched at d. The first `digest_valid` appears at d+2 for a final block; `in_ready` rises at d+2 otherwise.
- Digest: one word per cycle under continuous `digest_ready`. Data and lane are held while `digest_ready`=0.
- `in_ready`=0 in LAUNCH, WAIT, CAPTURE and SQUEEZE.
- Asynchronous reset mid-operation (any state) returns the block to ABSORB, e=0, `st`=0 and all outputs to their reset values. Nothing is resumed.

## Structure
- Shared package `rescue_pkg` holds:
  - `N_BITS`, `PRIME_MODULUS`, `STATE_SIZE`, `RATE`, `LANES`
  - `typedef logic [N_BITS-1:0] felt_t`
  - the FSM state enum `{ABSORB, LAUNCH, WAIT, CAPTURE, SQUEEZE}`
- Sub-module `mod_add_p`: combinational (a+b) mod p for a, b < p. Input reduction reuses it with b=0 plus a pre-subtract, or uses a separate conditional subtract. Only one `mod_add_p` instance is on the absorb path, muxed by slot/lane.

## Test plan
Stub permutation for all scenarios: identity (`perm_out = perm_state`), `perm_done` pulses 3 cycles after `perm_enable`.
- Single block, elements e = e+1 (1..26), `in_last` on e=25 → one `perm_enable` pulse. Digests lanes 0..12 = 1..13.
- Input 254-bit value p+5 at e=0, rest 0, `in_last` at e=25 → lane-0 digest = 5.
- Two blocks: lane-0 slot-0 element = p−1 in block 1 and 2 in block 2, all other elements 0 → two enable pulses. Lane-0 digest = 1 (mod-p wrap).
- `in_last` on e=3 with data 7,8,9,10 → launch in the next cycle. Digests lanes 0..3 = 7,8,9,10; lanes 4..12 = 0.
- `digest_ready` toggled 0/1 every cycle → 13 words in order, each held stable while stalled, no word duplicated or dropped.
- `reset` asserted during WAIT → all outputs at reset values immediately. A following single-block message of all 1s gives digests of 1.
